riscv_branch_unit: RTL and testbench
====================================

Name:
riscv_branch_unit

Overview:
- Branch-condition evaluation unit for the execute stage of the 64-bit RISC-V core.
- Compares two 64-bit register operands according to a 4-bit branch condition code.
- Produces a registered "branch taken" flag consumed by PC-select / flush logic in the following cycle.

Parameters:
- XLEN, 64, operand width in bits; all comparisons are XLEN wide.

Ports:
- i_riscv_branch_clk  input  1  core clock; all state updates on its rising edge.
- i_riscv_branch_rst_n  input  1  asynchronous, active-low reset.
- i_riscv_branch_cond  input  4  bit[3] = branch enable; bits[2:0] = RV funct3 branch code.
- i_riscv_branch_rs1data  input  XLEN  first operand (rs1).
- i_riscv_branch_rs2data  input  XLEN  second operand (rs2).
- o_riscv_branch_taken  output  1  registered taken decision.

Behaviour:
- Reset:
  - o_riscv_branch_taken = 0 while rst_n is low, asynchronously.
  - The first rising edge after deassertion samples normally.
- Latency: exactly 1 cycle. The inputs present at rising edge N determine o_riscv_branch_taken after edge N. No handshake; a new evaluation is made every cycle.
- Code map for cond[2:0] when cond[3] = 1:
  - 000 BEQ: taken if rs1 == rs2.
  - 001 BNE: taken if rs1 != rs2.
  - 100 BLT: taken if signed(rs1) < signed(rs2).
  - 101 BGE: taken if signed(rs1) >= signed(rs2).
  - 110 BLTU: taken if unsigned(rs1) < unsigned(rs2).
  - 111 BGEU: taken if unsigned(rs1) >= unsigned(rs2).
  - 010, 011: reserved; taken = 0.
- cond[3] = 0 (non-branch instruction): taken = 0 regardless of cond[2:0] and operands.
- Comparator:
  - Compute one XLEN+1-bit subtraction rs1 - rs2, with operands zero- or sign-extended per signedness.
  - Less-than = MSB of the difference; equal = (rs1 ^ rs2) == 0.
  - GE = !LT and BNE = !EQ; no separate comparators for these.
- Boundary conditions:
  - Signed compare treats 0x8000_0000_0000_0000 as the most negative value.
  - Unsigned compare treats 0xFFFF_FFFF_FFFF_FFFF as the maximum value.
  - Equal operands: BGE/BGEU taken, BLT/BLTU not taken.
- X/unknown inputs need not be handled; no internal state besides the output flop.
- Reset asserted mid-operation clears the output immediately; the pending decision is discarded.

Decomposition:
- Shared package riscv_pkg:
  - typedef enum logic [2:0] branch_funct_e {BEQ=3'b000, BNE=3'b001, BLT=3'b100, BGE=3'b101, BLTU=3'b110, BGEU=3'b111}.
  - localparam XLEN = 64.
- One sub-module, riscv_branch_cmp: purely combinational.
  - Inputs: rs1, rs2, is_unsigned.
  - Outputs: eq, lt.
- Top: decodes cond, selects the result, and registers it.

Test Plan:
- Reset: hold rst_n=0 with cond=4'b1000, rs1=rs2=5 -> taken=0. Release; after next edge -> taken=1 (BEQ equal).
- BEQ/BNE: rs1=64'h1234, rs2=64'h1235; cond=4'b1000 -> taken 0 next cycle; cond=4'b1001 -> taken 1. With rs1=rs2, the results invert.
- Signed vs unsigned: rs1=64'hFFFF_FFFF_FFFF_FFFF (-1), rs2=1.
  - BLT (1100) -> 1.
  - BGE (1101) -> 0.
  - BLTU (1110) -> 0.
  - BGEU (1111) -> 1.
- Extremes: rs1=64'h8000_0000_0000_0000, rs2=64'h7FFF_FFFF_FFFF_FFFF.
  - BLT -> 1.
  - BLTU -> 0.
  - rs1=rs2=64'h8000_0000_0000_0000: BGE -> 1, BGEU -> 1, BLT -> 0.
- Disable/reserved: cond=4'b0000 with rs1=rs2 -> 0; cond=4'b1010 and 4'b1011 with any operands -> 0.
- Pipelined stream: change cond/operands every cycle over 6 cycles -> each output equals the previous cycle's expected value; assert rst_n low mid-stream -> output drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: operand width and branch funct3 encodings.
package riscv_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct_e;

endpackage

// File: rtl/riscv_branch_cmp.sv
// Combinational branch comparator: one XLEN+1-bit subtraction yields less-than;
// equality comes from an XOR reduction.
module riscv_branch_cmp #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            is_unsigned,
    output logic            eq,
    output logic            lt
);

    logic [XLEN:0] op_a;
    logic [XLEN:0] op_b;
    logic [XLEN:0] diff;

    // The extension bit makes the MSB of the wide difference the exact less-than,
    // with no overflow case in either signedness.
    always_comb begin
        op_a = {(~is_unsigned & rs1[XLEN-1]), rs1};
        op_b = {(~is_unsigned & rs2[XLEN-1]), rs2};
        diff = op_a - op_b;
        lt   = diff[XLEN];
        eq   = ((rs1 ^ rs2) == '0);
    end

endmodule

// File: rtl/riscv_branch_unit.sv
// Execute-stage branch condition unit: decodes the condition code, compares
// rs1/rs2 and registers the taken decision for PC-select one cycle later.
module riscv_branch_unit #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            i_riscv_branch_clk,
    input  logic            i_riscv_branch_rst_n,
    input  logic [3:0]      i_riscv_branch_cond,
    input  logic [XLEN-1:0] i_riscv_branch_rs1data,
    input  logic [XLEN-1:0] i_riscv_branch_rs2data,
    output logic            o_riscv_branch_taken
);

    import riscv_pkg::*;

    logic          cmp_eq;
    logic          cmp_lt;
    logic          taken_d;
    logic          taken_q;
    branch_funct_e funct;

    // BLTU and BGEU are the only codes with funct3[1] set among the valid branches.
    riscv_branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rs1        (i_riscv_branch_rs1data),
        .rs2        (i_riscv_branch_rs2data),
        .is_unsigned(i_riscv_branch_cond[1]),
        .eq         (cmp_eq),
        .lt         (cmp_lt)
    );

    always_comb begin
        taken_d = 1'b0;
        funct   = branch_funct_e'(i_riscv_branch_cond[2:0]);
        if (i_riscv_branch_cond[3]) begin
            case (funct)
                BEQ:     taken_d = cmp_eq;
                BNE:     taken_d = ~cmp_eq;
                BLT:     taken_d = cmp_lt;
                BGE:     taken_d = ~cmp_lt;
                BLTU:    taken_d = cmp_lt;
                BGEU:    taken_d = ~cmp_lt;
                default: taken_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_riscv_branch_clk or negedge i_riscv_branch_rst_n) begin
        if (!i_riscv_branch_rst_n) begin
            taken_q <= 1'b0;
        end else begin
            taken_q <= taken_d;
        end
    end

    assign o_riscv_branch_taken = taken_q;

endmodule

// File: tb/tb_riscv_branch_unit.sv
// Directed self-checking bench for riscv_branch_unit with hand-computed expectations.
module tb_riscv_branch_unit;

   logic        clock;
   logic        resetN;
   logic [3:0]  cond;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        taken;

   int compareCount;
   int mismatchCount;

   logic [3:0]  streamCond [6];
   logic [63:0] streamRs1  [6];
   logic [63:0] streamRs2  [6];
   logic        streamExp  [6];

   riscv_branch_unit #(.XLEN(64)) dut (
      .i_riscv_branch_clk    (clock),
      .i_riscv_branch_rst_n  (resetN),
      .i_riscv_branch_cond   (cond),
      .i_riscv_branch_rs1data(rs1),
      .i_riscv_branch_rs2data(rs2),
      .o_riscv_branch_taken  (taken)
   );

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts one comparison and reports it when observed differs from expected
   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
      end
   endtask

   // Drives one evaluation on the falling edge and lets the next rising edge register it
   task automatic applyStimulus(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
      @(negedge clock);
      cond = c;
      rs1  = a;
      rs2  = b;
      @(posedge clock);
      #1;
   endtask

   // Main directed sequence: reset, per-code vectors, boundaries, then a pipelined stream
   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      resetN = 1'b0;
      cond   = 4'b1000;
      rs1    = 64'd5;
      rs2    = 64'd5;

      #3;
      checkOutput("reset_async", taken, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_held", taken, 1'b0);
      @(negedge clock);
      resetN = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("reset_release_beq", taken, 1'b1);

      applyStimulus(4'b1000, 64'h1234, 64'h1235);
      checkOutput("beq_ne", taken, 1'b0);
      applyStimulus(4'b1001, 64'h1234, 64'h1235);
      checkOutput("bne_ne", taken, 1'b1);
      applyStimulus(4'b1000, 64'h1234, 64'h1234);
      checkOutput("beq_eq", taken, 1'b1);
      applyStimulus(4'b1001, 64'h1234, 64'h1234);
      checkOutput("bne_eq", taken, 1'b0);

      applyStimulus(4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checkOutput("blt_m1_1", taken, 1'b1);
      applyStimulus(4'b1101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checkOutput("bge_m1_1", taken, 1'b0);
      applyStimulus(4'b1110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checkOutput("bltu_max_1", taken, 1'b0);
      applyStimulus(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checkOutput("bgeu_max_1", taken, 1'b1);

      applyStimulus(4'b1100, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
      checkOutput("blt_min_max", taken, 1'b1);
      applyStimulus(4'b1110, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
      checkOutput("bltu_min_max", taken, 1'b0);
      applyStimulus(4'b1101, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checkOutput("bge_min_eq", taken, 1'b1);
      applyStimulus(4'b1111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checkOutput("bgeu_min_eq", taken, 1'b1);
      applyStimulus(4'b1100, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checkOutput("blt_min_eq", taken, 1'b0);
      applyStimulus(4'b1110, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      checkOutput("bltu_min_eq", taken, 1'b0);

      applyStimulus(4'b0000, 64'd42, 64'd42);
      checkOutput("disabled_beq", taken, 1'b0);
      applyStimulus(4'b0111, 64'd0, 64'd9);
      checkOutput("disabled_bgeu", taken, 1'b0);
      applyStimulus(4'b1010, 64'd42, 64'd42);
      checkOutput("reserved_010", taken, 1'b0);
      applyStimulus(4'b1011, 64'd1, 64'd2);
      checkOutput("reserved_011", taken, 1'b0);

      // Back-to-back stream: each rising edge registers the vector driven just before it
      streamCond[0] = 4'b1000; streamRs1[0] = 64'd7;  streamRs2[0] = 64'd7; streamExp[0] = 1'b1;
      streamCond[1] = 4'b1001; streamRs1[1] = 64'd7;  streamRs2[1] = 64'd7; streamExp[1] = 1'b0;
      streamCond[2] = 4'b1110; streamRs1[2] = 64'd3;  streamRs2[2] = 64'd9; streamExp[2] = 1'b1;
      streamCond[3] = 4'b1101; streamRs1[3] = 64'd3;  streamRs2[3] = 64'd9; streamExp[3] = 1'b0;
      streamCond[4] = 4'b1100; streamRs1[4] = 64'hFFFF_FFFF_FFFF_FFFB; streamRs2[4] = 64'd2; streamExp[4] = 1'b1;
      streamCond[5] = 4'b1111; streamRs1[5] = 64'hFFFF_FFFF_FFFF_FFFB; streamRs2[5] = 64'd2; streamExp[5] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(streamCond[i], streamRs1[i], streamRs2[i]);
         checkOutput($sformatf("stream_%0d", i), taken, streamExp[i]);
      end

      applyStimulus(4'b1000, 64'd11, 64'd11);
      checkOutput("pre_midreset", taken, 1'b1);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("midreset_async", taken, 1'b0);
      @(negedge clock);
      resetN = 1'b1;
      applyStimulus(4'b1001, 64'd1, 64'd2);
      checkOutput("post_midreset", taken, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
